led_ctrl: RTL and testbench

LED_CTRL -- requirements
Module: led_ctrl

---
 rtl/led_ctrl_pkg.sv | 12 +
 rtl/led_chan.sv | 61 ++++++
 rtl/led_ctrl.sv | 66 ++++++
 tb/tb_led_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED controller: channel mode encodings.
// Imported by the top level and by every channel instance.
package led_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_PWM   = 2'd3
   } mode_t;

endpackage

// File: rtl/led_chan.sv
// One LED channel: holds its own mode/period/duty, runs a tick-driven counter
// and produces a registered LED drive plus a one-cycle wrap pulse.
module led_chan
   import led_ctrl_pkg::*;
#(
   parameter int               CNT_W      = 25,
   parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(25'd24_999_999)
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             tick,
   input  logic             wr,
   input  mode_t            wr_mode,
   input  logic [CNT_W-1:0] wr_period,
   input  logic [CNT_W-1:0] wr_duty,
   output logic             led,
   output logic             wrap
);

   mode_t            mode;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] duty;
   logic [CNT_W-1:0] cnt;
   logic             run;
   logic             at_end;

   assign run    = tick && ((mode == MODE_BLINK) || (mode == MODE_PWM));
   assign at_end = (cnt >= period);

   // A write restarts the channel from a clean state and suppresses any wrap
   // that would otherwise have happened in the same cycle.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         mode   <= MODE_OFF;
         period <= DEF_PERIOD;
         duty   <= '0;
         cnt    <= '0;
         led    <= 1'b0;
         wrap   <= 1'b0;
      end else if (wr) begin
         mode   <= wr_mode;
         period <= wr_period;
         duty   <= wr_duty;
         cnt    <= '0;
         led    <= (wr_mode == MODE_ON);
         wrap   <= 1'b0;
      end else begin
         wrap <= run && at_end;
         if (run) begin
            cnt <= at_end ? '0 : cnt + 1'b1;
         end
         unique case (mode)
            MODE_OFF:   led <= 1'b0;
            MODE_ON:    led <= 1'b1;
            MODE_BLINK: if (run && at_end) led <= ~led;
            MODE_PWM:   led <= (cnt < duty);
         endcase
      end
   end

endmodule

// File: rtl/led_ctrl.sv
// Multi-channel LED controller: shared tick prescaler, config write decode and
// NUM_CH independent led_chan instances.
module led_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int               NUM_CH     = 4,
   parameter int               CNT_W      = 25,
   parameter int               PRESCALE   = 1,
   parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(25'd24_999_999),
   localparam int              CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [1:0]        cfg_mode,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_duty,
   output logic [NUM_CH-1:0] led_out,
   output logic [NUM_CH-1:0] wrap_pulse
);

   localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   logic [PS_W-1:0] pre_cnt;
   logic            tick;
   logic            accept;

   assign tick      = (pre_cnt == PS_LAST);
   assign cfg_ready = sys_rst;
   assign accept    = cfg_valid && cfg_ready;

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   // Channel indices beyond NUM_CH match no instance, so such writes vanish.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
      logic wr;
      assign wr = accept && (32'(cfg_ch) == i);

      led_chan #(
         .CNT_W      (CNT_W),
         .DEF_PERIOD (DEF_PERIOD)
      ) u_chan (
         .sys_clk   (sys_clk),
         .sys_rst   (sys_rst),
         .tick      (tick),
         .wr        (wr),
         .wr_mode   (mode_t'(cfg_mode)),
         .wr_period (cfg_period),
         .wr_duty   (cfg_duty),
         .led       (led_out[i]),
         .wrap      (wrap_pulse[i])
      );
   end

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl: a 4-channel unprescaled instance and a
// 5-channel PRESCALE=4 instance sharing clock and reset.
module tb_led_ctrl;
   import led_ctrl_pkg::*;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b0;

   logic       cfg_valid_a = 1'b0;
   logic       cfg_ready_a;
   logic [1:0] cfg_ch_a = '0;
   logic [1:0] cfg_mode_a = '0;
   logic [7:0] cfg_period_a = '0;
   logic [7:0] cfg_duty_a = '0;
   logic [3:0] led_a;
   logic [3:0] wrap_a;

   logic       cfg_valid_b = 1'b0;
   logic       cfg_ready_b;
   logic [2:0] cfg_ch_b = '0;
   logic [1:0] cfg_mode_b = '0;
   logic [7:0] cfg_period_b = '0;
   logic [7:0] cfg_duty_b = '0;
   logic [4:0] led_b;
   logic [4:0] wrap_b;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         ch;
      logic [1:0] mode;
      logic [7:0] period;
      logic [7:0] duty;
      int         wait_cycles;
      logic       exp_led;
      logic       exp_wrap;
      string      name;
   } vec_t;

   vec_t vecs[13];

   led_ctrl #(
      .NUM_CH(4), .CNT_W(8), .PRESCALE(1), .DEF_PERIOD(8'd200)
   ) dut_a (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .cfg_valid  (cfg_valid_a),
      .cfg_ready  (cfg_ready_a),
      .cfg_ch     (cfg_ch_a),
      .cfg_mode   (cfg_mode_a),
      .cfg_period (cfg_period_a),
      .cfg_duty   (cfg_duty_a),
      .led_out    (led_a),
      .wrap_pulse (wrap_a)
   );

   led_ctrl #(
      .NUM_CH(5), .CNT_W(8), .PRESCALE(4), .DEF_PERIOD(8'd200)
   ) dut_b (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .cfg_valid  (cfg_valid_b),
      .cfg_ready  (cfg_ready_b),
      .cfg_ch     (cfg_ch_b),
      .cfg_mode   (cfg_mode_b),
      .cfg_period (cfg_period_b),
      .cfg_duty   (cfg_duty_b),
      .led_out    (led_b),
      .wrap_pulse (wrap_b)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   // Write edge is the posedge inside this task; returns 1 time unit after it.
   task automatic apply_stimulus(input int ch, input logic [1:0] mode,
                                 input logic [7:0] period, input logic [7:0] duty);
      @(negedge sys_clk);
      cfg_ch_a     = 2'(ch);
      cfg_mode_a   = mode;
      cfg_period_a = period;
      cfg_duty_a   = duty;
      cfg_valid_a  = 1'b1;
      @(posedge sys_clk);
      #1 cfg_valid_a = 1'b0;
   endtask

   task automatic apply_stimulus_b(input int ch, input logic [1:0] mode,
                                   input logic [7:0] period, input logic [7:0] duty);
      @(negedge sys_clk);
      cfg_ch_b     = 3'(ch);
      cfg_mode_b   = mode;
      cfg_period_b = period;
      cfg_duty_b   = duty;
      cfg_valid_b  = 1'b1;
      @(posedge sys_clk);
      #1 cfg_valid_b = 1'b0;
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic prev;
      int   last;
      int   toggles;

      vecs[0]  = '{3, MODE_ON,    8'd0, 8'd0,  1, 1'b1, 1'b0, "ch3 on"};
      vecs[1]  = '{3, MODE_OFF,   8'd0, 8'd0,  1, 1'b0, 1'b0, "ch3 off"};
      vecs[2]  = '{0, MODE_BLINK, 8'd3, 8'd0,  4, 1'b1, 1'b1, "ch0 blink p3 first wrap"};
      vecs[3]  = '{0, MODE_BLINK, 8'd3, 8'd0,  5, 1'b1, 1'b0, "ch0 blink p3 after wrap"};
      vecs[4]  = '{0, MODE_BLINK, 8'd0, 8'd0,  1, 1'b1, 1'b1, "ch0 blink p0 tick1"};
      vecs[5]  = '{0, MODE_BLINK, 8'd0, 8'd0,  2, 1'b0, 1'b1, "ch0 blink p0 tick2"};
      vecs[6]  = '{1, MODE_PWM,   8'd9, 8'd3,  3, 1'b1, 1'b0, "ch1 pwm d3 high"};
      vecs[7]  = '{1, MODE_PWM,   8'd9, 8'd3,  4, 1'b0, 1'b0, "ch1 pwm d3 low"};
      vecs[8]  = '{1, MODE_PWM,   8'd9, 8'd0,  2, 1'b0, 1'b0, "ch1 pwm d0"};
      vecs[9]  = '{1, MODE_PWM,   8'd9, 8'd10, 1, 1'b1, 1'b0, "ch1 pwm d10"};
      vecs[10] = '{1, MODE_PWM,   8'd9, 8'd10, 10, 1'b1, 1'b1, "ch1 pwm wrap"};
      vecs[11] = '{2, MODE_OFF,   8'd5, 8'd0,  3, 1'b0, 1'b0, "ch2 off"};
      vecs[12] = '{2, MODE_ON,    8'd0, 8'd0,  3, 1'b1, 1'b0, "ch2 on p0"};

      // Reset state
      repeat (3) @(posedge sys_clk);
      #1;
      check_output("reset led_a", 32'(led_a), 0);
      check_output("reset wrap_a", 32'(wrap_a), 0);
      check_output("reset ready_a", 32'(cfg_ready_a), 0);
      check_output("reset led_b", 32'(led_b), 0);
      check_output("reset ready_b", 32'(cfg_ready_b), 0);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      #1 check_output("ready after release", 32'(cfg_ready_a), 1);

      foreach (vecs[i]) begin
         apply_stimulus(vecs[i].ch, vecs[i].mode, vecs[i].period, vecs[i].duty);
         wait_edges(vecs[i].wait_cycles);
         check_output($sformatf("%s led", vecs[i].name), 32'(led_a[vecs[i].ch]),
                      32'(vecs[i].exp_led));
         check_output($sformatf("%s wrap", vecs[i].name), 32'(wrap_a[vecs[i].ch]),
                      32'(vecs[i].exp_wrap));
      end

      // BLINK period 3: toggle and wrap every 4 cycles
      apply_stimulus(0, MODE_BLINK, 8'd3, 8'd0);
      for (int k = 1; k <= 16; k++) begin
         wait_edges(1);
         check_output($sformatf("blink led k=%0d", k), 32'(led_a[0]), (k / 4) % 2);
         check_output($sformatf("blink wrap k=%0d", k), 32'(wrap_a[0]),
                      32'(k % 4 == 0));
      end

      // PWM period 9 duty 3: 3 high, 7 low
      apply_stimulus(1, MODE_PWM, 8'd9, 8'd3);
      for (int k = 1; k <= 20; k++) begin
         wait_edges(1);
         check_output($sformatf("pwm led k=%0d", k), 32'(led_a[1]),
                      32'(((k - 1) % 10) < 3));
         check_output($sformatf("pwm wrap k=%0d", k), 32'(wrap_a[1]),
                      32'(k % 10 == 0));
      end

      // Write landing in the wrap cycle of ch2
      apply_stimulus(2, MODE_BLINK, 8'd3, 8'd0);
      wait_edges(3);
      apply_stimulus(2, MODE_BLINK, 8'd3, 8'd0);
      check_output("wrap-cycle write wrap", 32'(wrap_a[2]), 0);
      check_output("wrap-cycle write led", 32'(led_a[2]), 0);
      for (int k = 1; k <= 4; k++) begin
         wait_edges(1);
         check_output($sformatf("rewrite wrap k=%0d", k), 32'(wrap_a[2]), 32'(k == 4));
         check_output($sformatf("rewrite led k=%0d", k), 32'(led_a[2]), 32'(k == 4));
      end

      // Prescaled instance: ch3 blink period 1, ignored write to ch5 mid-run
      apply_stimulus_b(0, MODE_ON, 8'd0, 8'd0);
      apply_stimulus_b(3, MODE_BLINK, 8'd1, 8'd0);
      prev    = led_b[3];
      last    = -1;
      toggles = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge sys_clk);
         if (i == 20) begin
            cfg_ch_b     = 3'd5;
            cfg_mode_b   = MODE_ON;
            cfg_period_b = 8'd0;
            cfg_valid_b  = 1'b1;
            check_output("ch5 write ready", 32'(cfg_ready_b), 1);
         end
         @(posedge sys_clk);
         #1 cfg_valid_b = 1'b0;
         if (led_b[3] != prev) begin
            toggles++;
            if (last >= 0) check_output("ch3 toggle interval", i - last, 8);
            last = i;
            prev = led_b[3];
         end
         if (i == 21) begin
            check_output("ch5 write other leds", 32'({led_b[4], led_b[2:0]}), 32'h1);
            check_output("ch5 write wraps", 32'({wrap_b[4], wrap_b[2:0]}), 0);
         end
      end
      check_output("ch3 toggle count ok", 32'(toggles >= 5), 1);

      // Asynchronous reset in the middle of BLINK
      apply_stimulus(0, MODE_BLINK, 8'd3, 8'd0);
      wait_edges(4);
      check_output("pre-reset led0", 32'(led_a[0]), 1);
      check_output("pre-reset wrap0", 32'(wrap_a[0]), 1);
      #2 sys_rst = 1'b0;
      #1;
      check_output("async reset led_a", 32'(led_a), 0);
      check_output("async reset wrap_a", 32'(wrap_a), 0);
      check_output("async reset ready_a", 32'(cfg_ready_a), 0);
      check_output("async reset led_b", 32'(led_b), 0);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      wait_edges(5);
      check_output("post-reset led_a", 32'(led_a), 0);
      check_output("post-reset wrap_a", 32'(wrap_a), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
